syscall_ctrl: RTL and testbench
===============================

SYSCALL_CTRL -- requirements
Module: syscall_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter MAX_STR_LEN, default 256, SHALL set the maximum number of characters emitted per print-string service.
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 syscall_req  in  1  single-cycle pulse: syscall instruction present in execute.
REQ-006 v0  in  32  service code, sampled with syscall_req.
REQ-007 a0  in  32  service argument (integer, character or string address), sampled with syscall_req.
REQ-008 stall  out  1  freeze pipeline while a service is in progress.
REQ-009 done  out  1  single-cycle pulse, service completed.
REQ-010 mem_req  out  1  byte read request to data memory.
REQ-011 mem_addr  out  32  byte address of the read.
REQ-012 mem_ack  in  1  read data valid this cycle.
REQ-013 mem_rdata  in  8  byte returned with mem_ack.
REQ-014 out_valid  out  1  console beat valid.
REQ-015 out_ready  in  1  console accepts beat.
REQ-016 out_data  out  32  integer value, or character zero-extended.
REQ-017 out_is_char  out  1  1 = character beat, 0 = signed-integer beat.
REQ-018 halt  out  1  execution-kill status, sticky.
REQ-019 err  out  1  sticky error: unknown service code or string truncated.

Function
REQ-020 States SHALL be IDLE, INT_OUT, CHR_OUT, STR_RD, STR_OUT, HALT.
REQ-021 In IDLE with syscall_req, the block SHALL latch v0/a0 and branch: 1 -> INT_OUT; 11 -> CHR_OUT; 4 -> STR_RD (ptr=a0, count=0); 10 -> HALT; any other code -> set err, remain IDLE, pulse done next cycle.
REQ-022 stall SHALL be combinational: high when state != IDLE, or when state == IDLE and syscall_req is high.
REQ-023 done SHALL be a registered pulse in the cycle after the FSM's return to IDLE; done is never asserted for HALT.
REQ-024 INT_OUT: out_valid=1, out_data=latched a0, out_is_char=0; on out_valid&out_ready -> IDLE.
REQ-025 CHR_OUT: out_valid=1, out_data={24'b0, a0[7:0]}, out_is_char=1; on handshake -> IDLE.
REQ-026 Once out_valid is asserted, it and out_data/out_is_char SHALL hold stable until out_ready is sampled high.
REQ-027 STR_RD: mem_req=1, mem_addr=ptr, held stable until mem_ack; on mem_ack, mem_rdata==0 -> IDLE (no beat); else latch byte -> STR_OUT.
REQ-028 STR_OUT: emit latched byte as character beat; on handshake, ptr+=1 (wraps modulo 2^32) and count+=1; if the new count==MAX_STR_LEN, set err and go to IDLE; else go to STR_RD.
REQ-029 Empty string (first byte 0) SHALL produce one memory read, zero beats, and a done pulse.
REQ-030 HALT: halt=1, stall=1, no beats or memory requests; exit only via rst.
REQ-031 syscall_req outside IDLE SHALL be ignored; mem_ack while mem_req is low SHALL be ignored.

Reset
REQ-032 rst SHALL force state IDLE and drive stall, done, mem_req, mem_addr, out_valid, out_data, out_is_char, halt and err to 0 immediately, including mid-service; any in-flight service is discarded.
REQ-033 The first syscall_req after rst deasserts SHALL be serviced normally.

Structure
REQ-034 Package syscall_pkg SHALL hold the state enum and service constants SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10, SYS_PRINT_CHAR=11.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 v0=1, a0=32'hFFFFFFFF, out_ready=1 -> exactly one beat, out_data=FFFFFFFF, out_is_char=0; done pulses once; stall drops afterwards.
REQ-037 v0=4, a0=0x100, memory "Hi\0", mem_ack latency 1 -> reads 0x100/0x101/0x102, beats 0x48 then 0x69, then done.
REQ-038 v0=11, a0=0x141, out_ready low 5 cycles -> out_data=0x41 held stable 6 cycles, done after the handshake.
REQ-039 v0=10 -> halt=1 next cycle; later syscall_req ignored; rst clears halt.
REQ-040 MAX_STR_LEN=4 with a 6-byte non-zero string -> exactly 4 beats, err=1; separately, v0=7 -> err=1, no beat, done pulse.
REQ-041 rst asserted after the second string beat -> all outputs 0 at once; a subsequent v0=1 service completes normally.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared state encoding, service codes and helpers for the syscall controller.
package syscall_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INT_OUT = 3'd1,
    CHR_OUT = 3'd2,
    STR_RD  = 3'd3,
    STR_OUT = 3'd4,
    HALT    = 3'd5
  } state_e;

  localparam logic [WORD_W-1:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [WORD_W-1:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [WORD_W-1:0] SYS_EXIT       = 32'd10;
  localparam logic [WORD_W-1:0] SYS_PRINT_CHAR = 32'd11;

  // Zero-extend a byte into a console character beat.
  function automatic logic [WORD_W-1:0] char_beat(input logic [BYTE_W-1:0] ch);
    return WORD_W'(ch);
  endfunction

endpackage

// File: rtl/syscall_ctrl.sv
// Syscall service controller: console int/char/string output and program exit.
module syscall_ctrl
  import syscall_pkg::*;
#(
  parameter int unsigned MAX_STR_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syscall_req,
  input  logic [WORD_W-1:0] v0,
  input  logic [WORD_W-1:0] a0,
  output logic              stall,
  output logic              done,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_is_char,
  output logic              halt,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(MAX_STR_LEN + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_d, err_d, halt_d;
  logic              mem_req_d, out_valid_d, out_is_char_d;
  logic [WORD_W-1:0] mem_addr_d, out_data_d;

  // Pipeline freeze: any active service, or a request arriving this cycle.
  assign stall = ~rst & ((state_q != IDLE) | syscall_req);

  // Next-state and next-output decode; mem_addr doubles as the string pointer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    err_d         = err;
    halt_d        = halt;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    out_valid_d   = out_valid;
    out_data_d    = out_data;
    out_is_char_d = out_is_char;
    case (state_q)
      IDLE: begin
        if (syscall_req) begin
          case (v0)
            SYS_PRINT_INT: begin
              state_d       = INT_OUT;
              out_valid_d   = 1'b1;
              out_data_d    = a0;
              out_is_char_d = 1'b0;
            end
            SYS_PRINT_CHAR: begin
              state_d       = CHR_OUT;
              out_valid_d   = 1'b1;
              out_data_d    = char_beat(a0[BYTE_W-1:0]);
              out_is_char_d = 1'b1;
            end
            SYS_PRINT_STR: begin
              state_d    = STR_RD;
              mem_req_d  = 1'b1;
              mem_addr_d = a0;
              cnt_d      = '0;
            end
            SYS_EXIT: begin
              state_d = HALT;
              halt_d  = 1'b1;
            end
            default: begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          endcase
        end
      end
      INT_OUT, CHR_OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      STR_RD: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_rdata == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d       = STR_OUT;
            out_valid_d   = 1'b1;
            out_data_d    = char_beat(mem_rdata);
            out_is_char_d = 1'b1;
          end
        end
      end
      STR_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          mem_addr_d  = mem_addr + WORD_W'(1);
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(MAX_STR_LEN)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d   = STR_RD;
            mem_req_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      halt        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_is_char <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done        <= done_d;
      err         <= err_d;
      halt        <= halt_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_is_char <= out_is_char_d;
    end
  end

endmodule

// File: tb/tb_syscall_ctrl.sv
// Self-checking bench for syscall_ctrl with a behavioural console/memory model.
module tb_syscall_ctrl;

  localparam int unsigned MAXLEN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        syscall_req = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        stall, done, mem_req, out_valid, out_is_char, halt, err;
  logic [31:0] mem_addr, out_data;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        out_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int lat = 1;
  int ready_mode = 0;
  bit stray_en = 1'b0;

  logic [32:0] beat_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_beat_q[$];
  bit [7:0]    mem [bit [31:0]];

  syscall_ctrl #(.MAX_STR_LEN(MAXLEN)) dut (
    .clk(clk), .rst(rst), .syscall_req(syscall_req), .v0(v0), .a0(a0),
    .stall(stall), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_is_char(out_is_char),
    .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Reference string walk: fills expected reads/beats, returns truncation flag.
  function automatic bit model_str(input bit [31:0] a);
    bit [31:0] p = a;
    bit [7:0]  b;
    int        n = 0;
    exp_addr_q.delete();
    exp_beat_q.delete();
    for (int i = 0; i <= int'(MAXLEN); i++) begin
      exp_addr_q.push_back(p);
      b = rd(p);
      if (b == 8'h00) return 1'b0;
      exp_beat_q.push_back(b);
      n++;
      p = p + 32'd1;
      if (n == int'(MAXLEN)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Console sink readiness.
  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Data memory with programmable ack latency and optional stray acks.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && !rst) begin
        if (wait_cnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (stray_en && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 8'($urandom_range(1, 255));
        end
      end
    end
  end

  // Record beats/reads/done and check handshake hold behaviour.
  initial begin
    logic        pv = 0, pr = 0, pq = 0, pa = 0, pc = 0;
    logic [31:0] pd = '0, pad = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; pr = 0; pq = 0; pa = 0;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (out_valid && out_ready) beat_q.push_back({out_is_char, out_data});
        if (mem_req && mem_ack) addr_q.push_back(mem_addr);
        if (pv && !pr) begin
          vectors++;
          if ({out_valid, out_is_char, out_data} !== {1'b1, pc, pd}) begin
            miscompares++;
            $display("FAIL beat_hold: got %b/%b/%h required 1/%b/%h", out_valid, out_is_char, out_data, pc, pd);
          end
        end
        if (pq && !pa) begin
          vectors++;
          if ({mem_req, mem_addr} !== {1'b1, pad}) begin
            miscompares++;
            $display("FAIL mem_hold: got %b/%h required 1/%h", mem_req, mem_addr, pad);
          end
        end
        pv = out_valid; pr = out_ready; pc = out_is_char; pd = out_data;
        pq = mem_req; pa = mem_ack; pad = mem_addr;
      end
    end
  end

  task automatic run_service(input logic [31:0] v, input logic [31:0] a, output bit timed_out);
    int d0 = done_cnt;
    @(posedge clk); #1;
    syscall_req = 1'b1; v0 = v; a0 = a;
    @(posedge clk); #1;
    syscall_req = 1'b0; v0 = $urandom; a0 = $urandom;
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin timed_out = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    syscall_req = 1'b1; v0 = 32'd1; a0 = 32'h5;
    repeat (2) @(negedge clk);
    vectors++;
    if ({stall, done, mem_req, mem_addr, out_valid, out_data, out_is_char, halt, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b done=%b req=%b addr=%h valid=%b data=%h char=%b halt=%b err=%b required all 0",
               stall, done, mem_req, mem_addr, out_valid, out_data, out_is_char, halt, err);
    end
    @(posedge clk); #1;
    syscall_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_int_exact();
    bit to; int d0 = done_cnt;
    ready_mode = 0; beat_q.delete();
    run_service(32'd1, 32'hFFFF_FFFF, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL int_timeout: got no done required done"); end
    vectors++;
    if (beat_q.size() != 1) begin
      miscompares++; $display("FAIL int_beats: got %0d required 1", beat_q.size());
    end else if (beat_q[0] !== {1'b0, 32'hFFFF_FFFF}) begin
      miscompares++; $display("FAIL int_data: got %h required %h", beat_q[0], {1'b0, 32'hFFFF_FFFF});
    end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL int_done: got %0d pulses required 1", done_cnt - d0); end
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL int_stall: got %b required 0", stall); end
  endtask

  task automatic test_int_char_random();
    bit to; logic [31:0] v, a; logic [32:0] exp; int d0;
    ready_mode = 1;
    for (int it = 0; it < 12; it++) begin
      v = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'd11;
      a = $urandom;
      exp = (v == 32'd1) ? {1'b0, a} : {1'b1, 24'h0, a[7:0]};
      beat_q.delete(); d0 = done_cnt;
      run_service(v, a, to);
      vectors++;
      if (to || beat_q.size() != 1 || done_cnt - d0 != 1) begin
        miscompares++;
        $display("FAIL ic_rand[%0d]: got timeout=%b beats=%0d dones=%0d required 0/1/1", it, to, beat_q.size(), done_cnt - d0);
      end else begin
        vectors++;
        if (beat_q[0] !== exp) begin
          miscompares++; $display("FAIL ic_rand_data[%0d]: got %h required %h", it, beat_q[0], exp);
        end
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_char_hold();
    int held = 0; int d0 = done_cnt; int d_pre = 0;
    ready_mode = 2; out_ready = 1'b0; beat_q.delete();
    @(posedge clk); #1;
    syscall_req = 1'b1; v0 = 32'd11; a0 = 32'h141;
    @(posedge clk); #1;
    syscall_req = 1'b0; v0 = $urandom; a0 = $urandom;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_data === 32'h41 && out_is_char === 1'b1) held++;
      if (i == 5) d_pre = done_cnt - d0;
      if (i == 4) begin @(posedge clk); #1; out_ready = 1'b1; end
    end
    @(negedge clk);
    vectors++;
    if (held != 6) begin miscompares++; $display("FAIL chr_held: got %0d cycles required 6", held); end
    vectors++;
    if (d_pre != 0) begin miscompares++; $display("FAIL chr_early_done: got %0d required 0", d_pre); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL chr_valid_drop: got %b required 0", out_valid); end
    repeat (3) @(negedge clk);
    vectors++;
    if (beat_q.size() != 1 || beat_q[0] !== {1'b1, 32'h41} || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL chr_result: got beats=%0d first=%h dones=%0d required 1/%h/1",
               beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 33'h0, done_cnt - d0, {1'b1, 32'h41});
    end
    ready_mode = 0;
  endtask

  task automatic test_string_directed();
    bit [7:0]  str [3][6] = '{'{8'h48, 8'h69, 8'h00, 8'h00, 8'h00, 8'h00},
                             '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                             '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46}};
    int        slen [3]    = '{2, 0, 6};
    bit [31:0] base [3]    = '{32'h100, 32'h200, 32'h300};
    int        nreads [3]  = '{3, 1, 4};
    int        nbeats [3]  = '{2, 0, 4};
    bit        eerr [3]    = '{1'b0, 1'b0, 1'b1};
    bit to; int d0;
    ready_mode = 0; lat = 1;
    for (int c = 0; c < 3; c++) begin
      mem.delete();
      for (int i = 0; i < slen[c]; i++) mem[base[c] + 32'(i)] = str[c][i];
      mem[base[c] + 32'(slen[c])] = 8'h00;
      beat_q.delete(); addr_q.delete(); d0 = done_cnt;
      run_service(32'd4, base[c], to);
      vectors++;
      if (to || addr_q.size() != nreads[c] || beat_q.size() != nbeats[c]) begin
        miscompares++;
        $display("FAIL str_dir[%0d]: got timeout=%b reads=%0d beats=%0d required 0/%0d/%0d",
                 c, to, addr_q.size(), beat_q.size(), nreads[c], nbeats[c]);
      end else begin
        for (int i = 0; i < nreads[c]; i++) begin
          vectors++;
          if (addr_q[i] !== base[c] + 32'(i)) begin
            miscompares++; $display("FAIL str_dir_addr[%0d][%0d]: got %h required %h", c, i, addr_q[i], base[c] + 32'(i));
          end
        end
        for (int i = 0; i < nbeats[c]; i++) begin
          vectors++;
          if (beat_q[i] !== {1'b1, 24'h0, str[c][i]}) begin
            miscompares++; $display("FAIL str_dir_beat[%0d][%0d]: got %h required %h", c, i, beat_q[i], {1'b1, 24'h0, str[c][i]});
          end
        end
      end
      vectors++;
      if (err !== eerr[c] || done_cnt - d0 != 1) begin
        miscompares++;
        $display("FAIL str_dir_end[%0d]: got err=%b dones=%0d required %b/1", c, err, done_cnt - d0, eerr[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to; bit seen = 1'b0; logic [31:0] a = $urandom;
    mem.delete();
    mem[32'h400] = 8'h61; mem[32'h401] = 8'h62; mem[32'h402] = 8'h63; mem[32'h403] = 8'h00;
    ready_mode = 0; lat = 1; beat_q.delete();
    @(posedge clk); #1;
    syscall_req = 1'b1; v0 = 32'd4; a0 = 32'h400;
    @(posedge clk); #1;
    syscall_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (beat_q.size() >= 2) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rmid_wait: got %0d beats required 2", beat_q.size()); end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({stall, done, mem_req, mem_addr, out_valid, out_data, out_is_char, halt, err} !== '0) begin
      miscompares++;
      $display("FAIL rmid_outputs: got stall=%b done=%b req=%b addr=%h valid=%b data=%h char=%b halt=%b err=%b required all 0",
               stall, done, mem_req, mem_addr, out_valid, out_data, out_is_char, halt, err);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (beat_q.size() != 2) begin miscompares++; $display("FAIL rmid_discard: got %0d beats required 2", beat_q.size()); end
    beat_q.delete();
    run_service(32'd1, a, to);
    vectors++;
    if (to || beat_q.size() != 1 || beat_q[0] !== {1'b0, a}) begin
      miscompares++;
      $display("FAIL rmid_after: got timeout=%b beats=%0d first=%h required 0/1/%h",
               to, beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 33'h0, {1'b0, a});
    end
  endtask

  task automatic test_string_random();
    bit to; bit err_model = 1'b0; bit [31:0] b; int len; int d0;
    ready_mode = 1; stray_en = 1'b1;
    for (int it = 0; it < 16; it++) begin
      lat = $urandom_range(0, 3);
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      len = $urandom_range(0, 6);
      mem.delete();
      for (int i = 0; i < len; i++) mem[b + 32'(i)] = 8'($urandom_range(1, 255));
      mem[b + 32'(len)] = 8'h00;
      err_model = err_model | model_str(b);
      beat_q.delete(); addr_q.delete(); d0 = done_cnt;
      run_service(32'd4, b, to);
      vectors++;
      if (to || addr_q.size() != exp_addr_q.size() || beat_q.size() != exp_beat_q.size()) begin
        miscompares++;
        $display("FAIL str_rand[%0d]: got timeout=%b reads=%0d beats=%0d required 0/%0d/%0d",
                 it, to, addr_q.size(), beat_q.size(), exp_addr_q.size(), exp_beat_q.size());
      end else begin
        for (int i = 0; i < exp_addr_q.size(); i++) begin
          vectors++;
          if (addr_q[i] !== exp_addr_q[i]) begin
            miscompares++; $display("FAIL str_rand_addr[%0d][%0d]: got %h required %h", it, i, addr_q[i], exp_addr_q[i]);
          end
        end
        for (int i = 0; i < exp_beat_q.size(); i++) begin
          vectors++;
          if (beat_q[i] !== {1'b1, 24'h0, exp_beat_q[i]}) begin
            miscompares++; $display("FAIL str_rand_beat[%0d][%0d]: got %h required %h", it, i, beat_q[i], {1'b1, 24'h0, exp_beat_q[i]});
          end
        end
      end
      vectors++;
      if (err !== err_model || done_cnt - d0 != 1) begin
        miscompares++;
        $display("FAIL str_rand_end[%0d]: got err=%b dones=%0d required %b/1", it, err, done_cnt - d0, err_model);
      end
    end
    stray_en = 1'b0; ready_mode = 0; lat = 1;
  endtask

  task automatic test_unknown();
    int d0 = done_cnt;
    beat_q.delete(); addr_q.delete();
    @(posedge clk); #1;
    syscall_req = 1'b1; v0 = 32'd7; a0 = $urandom;
    @(negedge clk);
    vectors++;
    if ({stall, done} !== 2'b10) begin miscompares++; $display("FAIL unk_req_cycle: got stall/done=%b%b required 10", stall, done); end
    @(posedge clk); #1;
    syscall_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done, err, stall} !== 3'b110) begin miscompares++; $display("FAIL unk_done: got done/err/stall=%b%b%b required 110", done, err, stall); end
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1 || beat_q.size() != 0 || addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL unk_quiet: got dones=%0d beats=%0d reads=%0d required 1/0/0", done_cnt - d0, beat_q.size(), addr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit to; logic [7:0] ch = 8'($urandom_range(1, 255)); logic [31:0] a = $urandom; int d0 = done_cnt;
    beat_q.delete(); addr_q.delete();
    ready_mode = 2; out_ready = 1'b0;
    @(posedge clk); #1; syscall_req = 1'b1; v0 = 32'd11; a0 = {24'hA5A5A5, ch};
    @(posedge clk); #1; v0 = 32'd10; a0 = $urandom;
    @(posedge clk); #1; v0 = 32'd4;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL b2b_stall: got %b required 1", stall); end
    @(posedge clk); #1; syscall_req = 1'b0; out_ready = 1'b1;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    run_service(32'd1, a, to);
    vectors++;
    if (to || halt !== 1'b0 || addr_q.size() != 0 || done_cnt - d0 != 2 || beat_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_summary: got timeout=%b halt=%b reads=%0d dones=%0d beats=%0d required 0/0/0/2/2",
               to, halt, addr_q.size(), done_cnt - d0, beat_q.size());
    end else begin
      vectors++;
      if (beat_q[0] !== {1'b1, 24'h0, ch} || beat_q[1] !== {1'b0, a}) begin
        miscompares++;
        $display("FAIL b2b_beats: got %h,%h required %h,%h", beat_q[0], beat_q[1], {1'b1, 24'h0, ch}, {1'b0, a});
      end
    end
  endtask

  task automatic test_halt();
    bit to; logic [31:0] a = $urandom; int d0 = done_cnt;
    beat_q.delete(); addr_q.delete();
    @(posedge clk); #1; syscall_req = 1'b1; v0 = 32'd10; a0 = $urandom;
    @(negedge clk);
    vectors++;
    if (halt !== 1'b0) begin miscompares++; $display("FAIL halt_early: got %b required 0", halt); end
    @(posedge clk); #1; syscall_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (halt !== 1'b1) begin miscompares++; $display("FAIL halt_set: got %b required 1", halt); end
    @(posedge clk); #1; syscall_req = 1'b1; v0 = 32'd1; a0 = $urandom;
    @(posedge clk); #1; syscall_req = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if ({halt, stall, out_valid, mem_req} !== 4'b1100 || beat_q.size() != 0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL halt_hold: got halt/stall/valid/req=%b%b%b%b beats=%0d dones=%0d required 1100/0/0",
               halt, stall, out_valid, mem_req, beat_q.size(), done_cnt - d0);
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    vectors++;
    if ({halt, stall, err} !== 3'b000) begin miscompares++; $display("FAIL halt_rst: got halt/stall/err=%b%b%b required 000", halt, stall, err); end
    @(posedge clk); #1 rst = 1'b0;
    run_service(32'd1, a, to);
    vectors++;
    if (to || beat_q.size() != 1 || beat_q[0] !== {1'b0, a}) begin
      miscompares++;
      $display("FAIL halt_after: got timeout=%b beats=%0d first=%h required 0/1/%h",
               to, beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 33'h0, {1'b0, a});
    end
  endtask

  initial begin
    test_reset();
    test_int_exact();
    test_int_char_random();
    test_char_hold();
    test_string_directed();
    test_reset_mid();
    test_string_random();
    test_unknown();
    test_back_to_back();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
